// File: rtl/rx_correlation_unit_mc_pkg.sv
// Shared types and helpers for the multi-lag rx chip correlator.
// Weight encoding, default chip windows and a saturating adder.
package rx_corr_pkg;

    typedef enum logic [1:0] {
        W_ZERO = 2'b00,
        W_POS  = 2'b01,
        W_NEG  = 2'b10
    } weight_e;

    localparam int DEF_NEG_LO = 2;
    localparam int DEF_NEG_HI = 4;
    localparam int DEF_POS_LO = 7;
    localparam int DEF_POS_HI = 9;

    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // Operands are sign-extended by the caller; the sum is clamped to a w-bit signed range.
    function automatic wide_t sat_add(input wide_t a, input wide_t b,
                                      input int unsigned w, output logic sat);
        wide_t sum;
        wide_t hi;
        wide_t lo;
        sum = a + b;
        hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo  = -hi - wide_t'(1);
        sat = 1'b0;
        if (sum > hi) begin
            sum = hi;
            sat = 1'b1;
        end else if (sum < lo) begin
            sum = lo;
            sat = 1'b1;
        end
        return sum;
    endfunction

endpackage

// File: rtl/rx_correlation_unit_mc_if.sv
// Sample/result bus of the multi-lag correlator.
// master = sample source and result consumer, slave = correlator.
interface rx_correlation_unit_mc_if #(
    parameter int N_LAGS   = 2,
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 20,
    parameter int PH_W     = 4
);
    logic                       erx_en;
    logic                       inew_sample_trig;
    logic [N_LAGS*SAMPLE_W-1:0] isamples;
    logic                       ipolarity;
    logic                       iready;
    logic                       ovalid;
    logic [N_LAGS*ACC_W-1:0]    oresults;
    logic [N_LAGS-1:0]          osat;
    logic [N_LAGS-1:0]          osign;
    logic                       ooverrun;
    logic [PH_W-1:0]            ophase;

    modport master (
        output erx_en, inew_sample_trig, isamples, ipolarity, iready,
        input  ovalid, oresults, osat, osign, ooverrun, ophase
    );

    modport slave (
        input  erx_en, inew_sample_trig, isamples, ipolarity, iready,
        output ovalid, oresults, osat, osign, ooverrun, ophase
    );
endinterface

// File: rtl/rx_corr_lane.sv
// One correlator lane: weighted saturating accumulator over a chip
// plus the result register loaded at the chip boundary.
module rx_corr_lane
    import rx_corr_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       acc_en,
    input  logic                       last,
    input  weight_e                    weight,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic signed [ACC_W-1:0]    result,
    output logic                       sat
);
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic                    sat_flag;
    logic                    hit;
    wide_t                   acc_w;
    wide_t                   add_w;

    always_comb begin
        acc_w = wide_t'(acc);
        case (weight)
            W_POS:   add_w = wide_t'(sample);
            W_NEG:   add_w = -wide_t'(sample);
            default: add_w = '0;
        endcase
        hit      = 1'b0;
        acc_next = ACC_W'(sat_add(acc_w, add_w, ACC_W, hit));
    end

    // The final sample of a chip goes straight into the result register, bypassing acc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            sat_flag <= 1'b0;
            result   <= '0;
            sat      <= 1'b0;
        end else if (clr) begin
            acc      <= '0;
            sat_flag <= 1'b0;
        end else if (acc_en) begin
            if (last) begin
                result   <= acc_next;
                sat      <= sat_flag | hit;
                acc      <= '0;
                sat_flag <= 1'b0;
            end else begin
                acc      <= acc_next;
                sat_flag <= sat_flag | hit;
            end
        end
    end

endmodule

// File: rtl/rx_correlation_unit_mc.sv
// Multi-lag PRBS chip correlator: phase counter, weight decode,
// per-lane accumulators and a valid/ready result register with overrun flag.
module rx_correlation_unit_mc
    import rx_corr_pkg::*;
#(
    parameter int SAMPLE_W         = 16,
    parameter int ACC_W            = 20,
    parameter int N_LAGS           = 2,
    parameter int SAMPLES_PER_CHIP = 10,
    parameter int SAMPLE_POSITION  = 0,
    parameter int NEG_LO           = DEF_NEG_LO,
    parameter int NEG_HI           = DEF_NEG_HI,
    parameter int POS_LO           = DEF_POS_LO,
    parameter int POS_HI           = DEF_POS_HI
) (
    input  logic                     crx_clk,
    input  logic                     rrx_rst,
    rx_correlation_unit_mc_if.slave  bus
);
    localparam int              PH_W    = $clog2(SAMPLES_PER_CHIP);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SAMPLES_PER_CHIP - 1);
    localparam logic [PH_W-1:0] PH_INIT = PH_W'(SAMPLE_POSITION);

    logic [PH_W-1:0]         phase;
    weight_e                 weight;
    logic                    in_neg;
    logic                    in_pos;
    logic                    acc_trig;
    logic                    final_trig;
    logic signed [ACC_W-1:0] lane_res [N_LAGS];
    logic                    lane_sat [N_LAGS];

    // Phase keeps running while disabled so chip alignment survives erx_en toggles.
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            phase <= PH_INIT;
        end else if (bus.inew_sample_trig) begin
            phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
        end
    end

    always_comb begin
        in_neg = (int'(phase) >= NEG_LO) && (int'(phase) <= NEG_HI);
        in_pos = (int'(phase) >= POS_LO) && (int'(phase) <= POS_HI);
        weight = W_ZERO;
        if (in_pos) begin
            weight = bus.ipolarity ? W_NEG : W_POS;
        end else if (in_neg) begin
            weight = bus.ipolarity ? W_POS : W_NEG;
        end
        acc_trig   = bus.erx_en && bus.inew_sample_trig;
        final_trig = acc_trig && (phase == PH_LAST);
    end

    for (genvar k = 0; k < N_LAGS; k++) begin : g_lane
        rx_corr_lane #(
            .SAMPLE_W (SAMPLE_W),
            .ACC_W    (ACC_W)
        ) u_lane (
            .clk    (crx_clk),
            .rst    (rrx_rst),
            .clr    (~bus.erx_en),
            .acc_en (acc_trig),
            .last   (final_trig),
            .weight (weight),
            .sample (bus.isamples[k*SAMPLE_W +: SAMPLE_W]),
            .result (lane_res[k]),
            .sat    (lane_sat[k])
        );
    end

    always_comb begin
        bus.oresults = '0;
        bus.osat     = '0;
        bus.osign    = '0;
        for (int unsigned k = 0; k < N_LAGS; k++) begin
            bus.oresults[k*ACC_W +: ACC_W] = lane_res[k];
            bus.osat[k]                    = lane_sat[k];
            bus.osign[k]                   = lane_res[k][ACC_W-1];
        end
        bus.ophase = phase;
    end

    // A new chip result wins over acceptance; overrun only when the old one was never read.
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            bus.ovalid   <= 1'b0;
            bus.ooverrun <= 1'b0;
        end else if (!bus.erx_en) begin
            bus.ovalid   <= 1'b0;
            bus.ooverrun <= 1'b0;
        end else if (final_trig) begin
            bus.ovalid <= 1'b1;
            if (bus.ovalid && !bus.iready) begin
                bus.ooverrun <= 1'b1;
            end
        end else if (bus.ovalid && bus.iready) begin
            bus.ovalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_correlation_unit_mc.sv
// Bench for rx_correlation_unit_mc: two instances (default and ACC_W=17/SAMPLE_POSITION=7)
// driven identically and compared every cycle against a chip-level reference model.
module tb_rx_correlation_unit_mc;
    localparam int SW   = 16;
    localparam int NL   = 2;
    localparam int SPC  = 10;
    localparam int AW_A = 20;
    localparam int AW_B = 17;
    localparam int SP_A = 0;
    localparam int SP_B = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en, trig, pol, rdy;
    logic [NL*SW-1:0] smp;
    bit chk_on = 1'b0;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rx_correlation_unit_mc_if #(.N_LAGS(NL), .SAMPLE_W(SW), .ACC_W(AW_A), .PH_W(4)) if_a ();
    rx_correlation_unit_mc_if #(.N_LAGS(NL), .SAMPLE_W(SW), .ACC_W(AW_B), .PH_W(4)) if_b ();

    assign if_a.erx_en = en;  assign if_a.inew_sample_trig = trig;  assign if_a.isamples = smp;
    assign if_a.ipolarity = pol;  assign if_a.iready = rdy;
    assign if_b.erx_en = en;  assign if_b.inew_sample_trig = trig;  assign if_b.isamples = smp;
    assign if_b.ipolarity = pol;  assign if_b.iready = rdy;

    rx_correlation_unit_mc #(.SAMPLE_W(SW), .ACC_W(AW_A), .N_LAGS(NL),
        .SAMPLES_PER_CHIP(SPC), .SAMPLE_POSITION(SP_A)) dut_a (
        .crx_clk(clk), .rrx_rst(rst), .bus(if_a.slave));
    rx_correlation_unit_mc #(.SAMPLE_W(SW), .ACC_W(AW_B), .N_LAGS(NL),
        .SAMPLES_PER_CHIP(SPC), .SAMPLE_POSITION(SP_B)) dut_b (
        .crx_clk(clk), .rrx_rst(rst), .bus(if_b.slave));

    // DUT outputs unpacked to integers
    longint d_res [2][NL];
    bit     d_sat [2][NL];
    bit     d_sign[2][NL];
    bit     d_valid[2];
    bit     d_ovr[2];
    int     d_ph[2];

    always_comb begin
        for (int k = 0; k < NL; k++) begin
            d_res[0][k]  = longint'($signed(if_a.oresults[k*AW_A +: AW_A]));
            d_res[1][k]  = longint'($signed(if_b.oresults[k*AW_B +: AW_B]));
            d_sat[0][k]  = if_a.osat[k];
            d_sat[1][k]  = if_b.osat[k];
            d_sign[0][k] = if_a.osign[k];
            d_sign[1][k] = if_b.osign[k];
        end
        d_valid[0] = if_a.ovalid;    d_valid[1] = if_b.ovalid;
        d_ovr[0]   = if_a.ooverrun;  d_ovr[1]   = if_b.ooverrun;
        d_ph[0]    = int'(if_a.ophase);
        d_ph[1]    = int'(if_b.ophase);
    end

    // Reference model: plain integer arithmetic over the chip rules
    int     accw[2] = '{AW_A, AW_B};
    int     spos[2] = '{SP_A, SP_B};
    int     m_phase[2];
    longint m_acc [2][NL];
    bit     m_satf[2][NL];
    longint m_res [2][NL];
    bit     m_rsat[2][NL];
    bit     m_valid[2];
    bit     m_ovr[2];

    function automatic int wgt(input int ph, input bit p);
        int w = 0;
        if (ph >= 2 && ph <= 4) w = -1;
        else if (ph >= 7 && ph <= 9) w = 1;
        return p ? -w : w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_phase[d] = spos[d];
                m_valid[d] = 0;
                m_ovr[d] = 0;
                for (int k = 0; k < NL; k++) begin
                    m_acc[d][k] = 0; m_satf[d][k] = 0; m_res[d][k] = 0; m_rsat[d][k] = 0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit fin;
                fin = trig && en && (m_phase[d] == SPC - 1);
                if (!en) begin
                    m_valid[d] = 0;
                    m_ovr[d] = 0;
                    for (int k = 0; k < NL; k++) begin m_acc[d][k] = 0; m_satf[d][k] = 0; end
                end else begin
                    if (trig) begin
                        for (int k = 0; k < NL; k++) begin
                            longint s, a, lim;
                            bit hit;
                            s   = longint'($signed(smp[k*SW +: SW]));
                            a   = m_acc[d][k] + longint'(wgt(m_phase[d], pol)) * s;
                            lim = longint'(1) << (accw[d] - 1);
                            hit = 0;
                            if (a > lim - 1) begin a = lim - 1; hit = 1; end
                            if (a < -lim)    begin a = -lim;    hit = 1; end
                            if (fin) begin
                                m_res[d][k]  = a;
                                m_rsat[d][k] = m_satf[d][k] | hit;
                                m_acc[d][k]  = 0;
                                m_satf[d][k] = 0;
                            end else begin
                                m_acc[d][k]  = a;
                                m_satf[d][k] = m_satf[d][k] | hit;
                            end
                        end
                    end
                    if (fin) begin
                        if (m_valid[d] && !rdy) m_ovr[d] = 1;
                        m_valid[d] = 1;
                    end else if (m_valid[d] && rdy) begin
                        m_valid[d] = 0;
                    end
                end
                if (trig) m_phase[d] = (m_phase[d] + 1) % SPC;
            end
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d ovalid", d), d_valid[d], m_valid[d]);
                check($sformatf("d%0d ooverrun", d), d_ovr[d], m_ovr[d]);
                check($sformatf("d%0d ophase", d), d_ph[d], m_phase[d]);
                if (m_valid[d]) begin
                    for (int k = 0; k < NL; k++) begin
                        check($sformatf("d%0d result[%0d]", d, k), d_res[d][k], m_res[d][k]);
                        check($sformatf("d%0d osat[%0d]", d, k), d_sat[d][k], m_rsat[d][k]);
                        check($sformatf("d%0d osign[%0d]", d, k), d_sign[d][k], m_res[d][k] < 0);
                    end
                end
            end
        end
    end

    function automatic logic [NL*SW-1:0] pack(input int l0, input int l1);
        logic [SW-1:0] a, b;
        a = SW'(l0);
        b = SW'(l1);
        return {b, a};
    endfunction

    task automatic trigger(input logic [NL*SW-1:0] s, input logic r);
        @(negedge clk);
        smp = s; trig = 1'b1; rdy = r;
        @(negedge clk);
        trig = 1'b0;
    endtask

    // One chip on instance A's phase grid: n* on the -1 window, p* on the +1 window
    task automatic chip(input int n0, input int p0, input int n1, input int p1,
                        input logic r_mid, input logic r_last);
        for (int i = 0; i < SPC; i++) begin
            int ph, l0, l1;
            ph = m_phase[0];
            l0 = (ph >= 2 && ph <= 4) ? n0 : (ph >= 7 && ph <= 9) ? p0 : 0;
            l1 = (ph >= 2 && ph <= 4) ? n1 : (ph >= 7 && ph <= 9) ? p1 : 0;
            trigger(pack(l0, l1), (i == SPC - 1) ? r_last : r_mid);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst d%0d ovalid", d), d_valid[d], 0);
            check($sformatf("rst d%0d ooverrun", d), d_ovr[d], 0);
            check($sformatf("rst d%0d ophase", d), d_ph[d], spos[d]);
            for (int k = 0; k < NL; k++) begin
                check($sformatf("rst d%0d result[%0d]", d, k), d_res[d][k], 0);
                check($sformatf("rst d%0d osat[%0d]", d, k), d_sat[d][k], 0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        en = 1'b1; trig = 1'b0; pol = 1'b0; rdy = 1'b1; smp = '0;
        do_reset();
        chk_on = 1'b1;

        // Instance B starts at phase 7: partial first chip, saturation at ACC_W=17
        for (int i = 0; i < 3; i++) trigger(pack(32767, 10), 1'b1);
        check("sat valid", d_valid[1], 1);
        check("sat lane0", d_res[1][0], 65535);
        check("sat osat0", d_sat[1][0], 1);
        check("partial lane1", d_res[1][1], 30);
        check("partial osat1", d_sat[1][1], 0);
        for (int i = 0; i < SPC; i++) trigger(pack(0, 10), 1'b1);
        check("post-sat valid", d_valid[1], 1);
        check("post-sat lane0", d_res[1][0], 0);
        check("post-sat osat0", d_sat[1][0], 0);
        check("const10 lane1", d_res[1][1], 0);

        do_reset();
        chip(100, 0, 0, 50, 1'b1, 1'b1);
        check("pol0 valid", d_valid[0], 1);
        check("pol0 lane0", d_res[0][0], -300);
        check("pol0 lane1", d_res[0][1], 150);
        check("pol0 osign", if_a.osign, 2'b01);
        check("pol0 osat", if_a.osat, 2'b00);
        pol = 1'b1;
        chip(100, 0, 0, 50, 1'b1, 1'b1);
        check("pol1 lane0", d_res[0][0], 300);
        check("pol1 lane1", d_res[0][1], -150);
        check("pol1 osign", if_a.osign, 2'b10);
        pol = 1'b0;

        // Overrun: two unread chips, then accept, then disable to clear the sticky flag
        chip(0, 10, 0, 0, 1'b0, 1'b0);
        check("ovr chip1 valid", d_valid[0], 1);
        check("ovr chip1 flag", d_ovr[0], 0);
        check("ovr chip1 lane0", d_res[0][0], 30);
        chip(0, 20, 0, 0, 1'b0, 1'b0);
        check("ovr chip2 flag", d_ovr[0], 1);
        check("ovr chip2 lane0", d_res[0][0], 60);
        @(negedge clk) rdy = 1'b1;
        @(negedge clk) rdy = 1'b0;
        check("accept valid", d_valid[0], 0);
        check("accept sticky", d_ovr[0], 1);
        repeat (3) @(negedge clk);
        check("sticky held", d_ovr[0], 1);
        @(negedge clk) en = 1'b0;
        @(negedge clk) en = 1'b1;
        check("disable clears ovr", d_ovr[0], 0);

        // Accept in the same cycle as the next final trigger: no overrun
        chip(0, 5, 0, 0, 1'b0, 1'b0);
        check("pre same-cycle lane0", d_res[0][0], 15);
        chip(0, 7, 0, 0, 1'b0, 1'b1);
        check("same-cycle valid", d_valid[0], 1);
        check("same-cycle ovr", d_ovr[0], 0);
        check("same-cycle lane0", d_res[0][0], 21);

        // Async reset mid-chip with a pending result and overrun
        chip(0, 1, 0, 0, 1'b0, 1'b0);
        chip(0, 2, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) trigger(pack(0, 0), 1'b0);
        check("pre-rst ovr", d_ovr[0], 1);
        check("pre-rst valid", d_valid[0], 1);
        check("pre-rst phase", d_ph[0], 5);
        do_reset();

        // Disabled: phase tracks triggers, nothing reported
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            trigger(pack(1000, -1000), 1'b0);
            check("disabled valid", d_valid[0], 0);
        end
        en = 1'b1;
        check("disabled phase a", d_ph[0], 4);
        check("disabled phase b", d_ph[1], 1);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            trig = ($urandom_range(0, 1) == 1);
            smp  = {$urandom, $urandom};
            pol  = ($urandom_range(0, 3) == 0);
            rdy  = ($urandom_range(0, 3) != 0);
            en   = ($urandom_range(0, 40) != 0);
        end
        @(negedge clk);
        trig = 1'b0; en = 1'b1;
        repeat (2) @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
